// File: rtl/auth_pkg.sv
// rtl/auth_pkg.sv - shared constants, state encoding and field offsets for the auth response transmitter
`ifndef MSG_LEN
`define MSG_LEN 2080
`endif

package auth_pkg;

    localparam int unsigned MSG_LEN_DEFAULT = `MSG_LEN;

    localparam logic [7:0] PROTO_VERSION = 8'h01;

    localparam logic [7:0] MT_DIGESTS         = 8'h01;
    localparam logic [7:0] MT_CERTIFICATE     = 8'h02;
    localparam logic [7:0] MT_CHALLENGE_AUTH  = 8'h03;
    localparam logic [7:0] MT_ERROR           = 8'h7F;
    localparam logic [7:0] MT_GET_DIGESTS     = 8'h81;
    localparam logic [7:0] MT_GET_CERTIFICATE = 8'h82;
    localparam logic [7:0] MT_CHALLENGE       = 8'h83;

    // Header is version, type, param1, param2 packed MSB first ahead of the payload.
    localparam int unsigned HDR_W       = 32;
    localparam int unsigned VER_MSB     = MSG_LEN_DEFAULT - 1;
    localparam int unsigned TYPE_MSB    = MSG_LEN_DEFAULT - 9;
    localparam int unsigned P1_MSB      = MSG_LEN_DEFAULT - 17;
    localparam int unsigned P2_MSB      = MSG_LEN_DEFAULT - 25;
    localparam int unsigned PAYLOAD_MSB = MSG_LEN_DEFAULT - 33;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESENT      = 2'd1,
        ST_BACKOFF      = 2'd2,
        ST_WAIT_ACK_LOW = 2'd3
    } tx_state_e;

    function automatic logic is_response_type(input logic [7:0] t);
        return (t == MT_DIGESTS) || (t == MT_CERTIFICATE) ||
               (t == MT_CHALLENGE_AUTH) || (t == MT_ERROR);
    endfunction

endpackage

// File: rtl/auth_ack_timer.sv
// rtl/auth_ack_timer.sv - acknowledge timeout counter and retry counter, both saturating
module auth_ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    input  logic retry_inc_i,
    output logic timeout_o,
    output logic exhausted_o
);

    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_TOP = RW'(MAX_RETRY);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;

    // A retry restarts the window, so the timeout count is already zero on re-entry.
    always_comb begin
        tcnt_d = tcnt_q;
        rcnt_d = rcnt_q;
        if (clear_i) begin
            tcnt_d = '0;
            rcnt_d = '0;
        end else if (retry_inc_i) begin
            tcnt_d = '0;
            if (rcnt_q != RETRY_TOP) rcnt_d = rcnt_q + 1'b1;
        end else if (enable_i && (tcnt_q != TO_LAST)) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
            rcnt_q <= rcnt_d;
        end
    end

    assign timeout_o   = enable_i && (tcnt_q == TO_LAST);
    assign exhausted_o = (rcnt_q == RETRY_TOP);

endmodule

// File: rtl/auth_msg_tx.sv
// rtl/auth_msg_tx.sv - auth response message transmitter with ack timeout/retry; AUTH_TX_TYPE_CHECK_EN rejects unknown types
module auth_msg_tx
    import auth_pkg::*;
#(
    parameter int unsigned MSG_LEN     = `MSG_LEN,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_start,
    input  logic [7:0]         tx_type,
    input  logic [7:0]         tx_param1,
    input  logic [7:0]         tx_param2,
    input  logic [MSG_LEN-33:0] tx_payload,
    input  logic               tx_resp_req,
    input  logic               Ack_in_driver,
    output logic [MSG_LEN-1:0] auth_msg_out,
    output logic               auth_msg_ready,
    output logic               resp_req_out,
    output logic               tx_busy,
    output logic               tx_done,
    output logic               tx_error
);

    tx_state_e          state_q, state_d;
    logic [MSG_LEN-1:0] msg_q;
    logic               resp_q;
    logic               ready_q, resp_out_q, busy_q, done_q, error_q;

    logic capture, done_d, error_d;
    logic t_clear, t_en, t_retry, timeout, exhausted;
    logic type_ok;

`ifdef AUTH_TX_TYPE_CHECK_EN
    assign type_ok = is_response_type(tx_type);
`else
    assign type_ok = 1'b1;
`endif

    auth_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .MAX_RETRY   (MAX_RETRY)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (t_clear),
        .enable_i    (t_en),
        .retry_inc_i (t_retry),
        .timeout_o   (timeout),
        .exhausted_o (exhausted)
    );

    // Acknowledge is checked before timeout so a coincident ack completes the message.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        t_clear = 1'b0;
        t_en    = 1'b0;
        t_retry = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    if (type_ok) begin
                        capture = 1'b1;
                        t_clear = 1'b1;
                        state_d = ST_PRESENT;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_PRESENT: begin
                t_en = 1'b1;
                if (Ack_in_driver) begin
                    done_d  = 1'b1;
                    state_d = ST_WAIT_ACK_LOW;
                end else if (timeout) begin
                    if (!exhausted) begin
                        t_retry = 1'b1;
                        state_d = ST_BACKOFF;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BACKOFF:      state_d = ST_PRESENT;
            ST_WAIT_ACK_LOW: if (!Ack_in_driver) state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            msg_q      <= '0;
            resp_q     <= 1'b0;
            ready_q    <= 1'b0;
            resp_out_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= (state_d == ST_PRESENT);
            resp_out_q <= (state_d == ST_PRESENT) && (capture ? tx_resp_req : resp_q);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= done_d;
            error_q    <= error_d;
            if (capture) begin
                msg_q  <= {PROTO_VERSION, tx_type, tx_param1, tx_param2, tx_payload};
                resp_q <= tx_resp_req;
            end
        end
    end

    assign auth_msg_out   = msg_q;
    assign auth_msg_ready = ready_q;
    assign resp_req_out   = resp_out_q;
    assign tx_busy        = busy_q;
    assign tx_done        = done_q;
    assign tx_error       = error_q;

endmodule
